// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter that shares one single-port word memory between an
//   instruction-fetch requester (port 0) and a load/store requester (port 1).
//   Each transfer runs IDLE -> ACCESS -> DONE, one cycle per state.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   reqN_i, weN_i, addrN_i, wdataN_i  requester N command (held while req high)
//   gntN_o                            requester N owns the memory (ACCESS)
//   doneN_o, errN_o                   one-cycle completion pulse, range error
//   rdataN_o                          requester N read data (held until next read)
//   mem_addr_o, mem_din_o             memory address / write data
//   mem_we_o, mem_re_o                memory write / read strobes
//   mem_out_i                         memory combinational read data
module mem_arbiter_rr #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          gnt0_o,
  output logic          done0_o,
  output logic          err0_o,
  output logic [DW-1:0] rdata0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt1_o,
  output logic          done1_o,
  output logic          err1_o,
  output logic [DW-1:0] rdata1_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  input  logic [DW-1:0] mem_out_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  // last_grant_q is also the owner of the transfer in flight, since it is
  // updated at the same edge the winner's command is captured.
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic win_s;
  logic any_req_s;
  logic in_range_s;
  logic acc_s;
  logic dn_s;

  assign any_req_s  = req0_i | req1_i;
  assign in_range_s = (addr_q < AW'(DEPTH));
  assign acc_s      = (state_q == ST_ACCESS);
  assign dn_s       = (state_q == ST_DONE);

  // Arbitration: a tie goes to the port that was not granted last.
  always_comb begin
    win_s = last_grant_q;
    if (req0_i && req1_i) begin
      win_s = ~last_grant_q;
    end else if (req0_i) begin
      win_s = 1'b0;
    end else if (req1_i) begin
      win_s = 1'b1;
    end else begin
      win_s = last_grant_q;
    end
  end

  // Next-state and datapath register update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          state_d      = ST_ACCESS;
          last_grant_d = win_s;
          we_d         = win_s ? we1_i    : we0_i;
          addr_d       = win_s ? addr1_i  : addr0_i;
          wdata_d      = win_s ? wdata1_i : wdata0_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_DONE;
        err_d   = ~in_range_s;
        // Out-of-range forces the owner's rdata to zero; writes keep it.
        if (!in_range_s) begin
          if (last_grant_q) begin
            rdata1_d = '0;
          end else begin
            rdata0_d = '0;
          end
        end else if (!we_q) begin
          if (last_grant_q) begin
            rdata1_d = mem_out_i;
          end else begin
            rdata0_d = mem_out_i;
          end
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Strobes decode from the state register only, so an async reset during
  // ACCESS removes mem_we before the next edge.
  assign mem_we_o   = acc_s & in_range_s & we_q;
  assign mem_re_o   = acc_s & in_range_s & ~we_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o  = wdata_q;

  assign gnt0_o  = acc_s & ~last_grant_q;
  assign gnt1_o  = acc_s &  last_grant_q;
  assign done0_o = dn_s  & ~last_grant_q;
  assign done1_o = dn_s  &  last_grant_q;
  assign err0_o  = dn_s  & ~last_grant_q & err_q;
  assign err1_o  = dn_s  &  last_grant_q & err_q;

  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with a behavioural 256-word memory.
module tb_mem_arbiter_rr;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, done0, err0, gnt1, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_din, mem_out;
  logic        mem_we, mem_re;

  logic        tb_wr;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;
  logic [31:0] mem [256];

  int errors = 0;
  int checks = 0;

  mem_arbiter_rr #(.AW(32), .DW(32), .DEPTH(256)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
    .gnt0_o(gnt0), .done0_o(done0), .err0_o(err0), .rdata0_o(rdata0),
    .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
    .gnt1_o(gnt1), .done1_o(done1), .err1_o(err1), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_out_i(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge; tb port preloads.
  assign mem_out = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    else if (mem_we && mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer on a single port with per-cycle checks.
  task automatic xfer(input string tag, input logic p, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    tick();  // ACCESS
    chk({tag, ".gnt"},    {31'd0, p ? gnt1 : gnt0}, 32'd1);
    chk({tag, ".gnt_x"},  {31'd0, p ? gnt0 : gnt1}, 32'd0);
    chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, w & ~exp_err});
    chk({tag, ".mem_re"}, {31'd0, mem_re}, {31'd0, ~w & ~exp_err});
    if (!exp_err) chk({tag, ".mem_addr"}, mem_addr, a);
    tick();  // DONE
    chk({tag, ".done"},   {31'd0, p ? done1 : done0}, 32'd1);
    chk({tag, ".err"},    {31'd0, p ? err1 : err0}, {31'd0, exp_err});
    chk({tag, ".gnt_dn"}, {31'd0, gnt0 | gnt1}, 32'd0);
    chk({tag, ".we_dn"},  {31'd0, mem_we | mem_re}, 32'd0);
    if (!w || exp_err) chk({tag, ".rdata"}, p ? rdata1 : rdata0, exp_rd);
    req0 = 1'b0; req1 = 1'b0;
    tick();  // IDLE
    chk({tag, ".done_off"}, {31'd0, done0 | done1 | err0 | err1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    tb_wr = 1'b1; tb_wa = 8'd3; tb_wd = 32'd17;
    tick();
    tb_wa = 8'd7; tb_wd = 32'h0000_0077;
    tick();
    tb_wr = 1'b0;
    // Reset state
    chk("rst.gnt",   {30'd0, gnt0, gnt1}, 32'd0);
    chk("rst.done",  {28'd0, done0, done1, err0, err1}, 32'd0);
    chk("rst.strb",  {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst.addr",  mem_addr, 32'd0);
    chk("rst.din",   mem_din, 32'd0);
    chk("rst.rd0",   rdata0, 32'd0);
    chk("rst.rd1",   rdata1, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle.gnt",  {30'd0, gnt0, gnt1}, 32'd0);

    // 1: port 0 read of word 3
    xfer("t1", 1'b0, 1'b0, 32'd3, 32'd0, 32'd17, 1'b0);
    // 2: port 1 reads word 3, writes word 5, then port 0 reads word 5
    xfer("t2a", 1'b1, 1'b0, 32'd3, 32'd0, 32'd17, 1'b0);
    xfer("t2b", 1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    chk("t2.rd1_keep", rdata1, 32'd17);
    chk("t2.din", mem_din, 32'hDEAD_BEEF);
    xfer("t2c", 1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 1'b0);
    chk("t2.rd1_keep2", rdata1, 32'd17);

    // 3: both ports held high after reset -> 0,1,0,1 every 3 cycles
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd5;
    for (int t = 1; t <= 12; t++) begin
      logic g, d, pp;
      tick();
      g  = ((t % 3) == 1);
      d  = ((t % 3) == 2);
      pp = (((t - 1) / 3) % 2) == 1;
      chk($sformatf("t3.gnt0@%0d", t),  {31'd0, gnt0},  {31'd0, g & ~pp});
      chk($sformatf("t3.gnt1@%0d", t),  {31'd0, gnt1},  {31'd0, g & pp});
      chk($sformatf("t3.done0@%0d", t), {31'd0, done0}, {31'd0, d & ~pp});
      chk($sformatf("t3.done1@%0d", t), {31'd0, done1}, {31'd0, d & pp});
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("t3.rd0", rdata0, 32'd17);
    chk("t3.rd1", rdata1, 32'hDEAD_BEEF);

    // 4: out-of-range read
    xfer("t4", 1'b0, 1'b0, 32'd256, 32'd0, 32'd0, 1'b0 | 1'b1);

    // 5: reset during ACCESS of a port 1 write to word 7
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd7; wdata1 = 32'h1234_5678;
    tick();
    chk("t5.gnt1", {31'd0, gnt1}, 32'd1);
    chk("t5.we_pre", {31'd0, mem_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5.we_rst", {31'd0, mem_we}, 32'd0);
    chk("t5.gnt_rst", {31'd0, gnt1}, 32'd0);
    req1 = 1'b0;
    tick();
    chk("t5.done1", {31'd0, done1}, 32'd0);
    chk("t5.mem7", mem[7], 32'h0000_0077);
    rst = 1'b0;
    tick();
    chk("t5.done1b", {31'd0, done1 | err1}, 32'd0);
    chk("t5.idle", {30'd0, gnt0, gnt1}, 32'd0);
    xfer("t5r", 1'b0, 1'b0, 32'd7, 32'd0, 32'h0000_0077, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
